// File: rtl/nlfsr_pkg.sv
// Shared types and combination helpers for the NLFSR tap sequencer and its tester bench.
package nlfsr_pkg;

  localparam int unsigned TAP_W    = 8;
  localparam int unsigned MAX_TAPS = 23;
  localparam int unsigned COMB_W   = MAX_TAPS * TAP_W;

  typedef logic [COMB_W-1:0] comb_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    RECORD,
    ADVANCE,
    DONE
  } state_t;

  // First combination {1,2,..,k}; tap 1 lives in the least significant byte.
  function automatic comb_t first_comb(input int unsigned k);
    comb_t res;
    res = '0;
    for (int unsigned i = 0; i < MAX_TAPS; i++) begin
      if (i < k) res[i*TAP_W +: TAP_W] = TAP_W'(i + 1);
    end
    return res;
  endfunction

  // Lexicographic successor of a strictly increasing tap list drawn from 1..m.
  // Caller must not pass the final combination.
  function automatic comb_t next_comb(input comb_t comb, input int unsigned k,
                                      input int unsigned m);
    comb_t        res;
    int unsigned  piv;
    res = comb;
    piv = 0;
    for (int unsigned i = 0; i < MAX_TAPS; i++) begin
      if (i < k && 32'(comb[i*TAP_W +: TAP_W]) < (m - k + i + 1)) piv = i;
    end
    res[piv*TAP_W +: TAP_W] = comb[piv*TAP_W +: TAP_W] + TAP_W'(1);
    for (int unsigned i = 1; i < MAX_TAPS; i++) begin
      if (i > piv && i < k) res[i*TAP_W +: TAP_W] = res[(i-1)*TAP_W +: TAP_W] + TAP_W'(1);
    end
    return res;
  endfunction

  // Saturating event counter increment.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/nlfsr_result_fifo.sv
// Synchronous result FIFO; a push while full is accepted when a pop happens in the same cycle.
module nlfsr_result_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // Storage array; no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/nlfsr_tap_sequencer.sv
// Sweeps every strictly increasing tap combination through one NLFSR period tester
// and queues the combinations it reports as maximal-period.
module nlfsr_tap_sequencer
  import nlfsr_pkg::*;
#(
  parameter int unsigned SIZE        = 11,
  parameter int unsigned NUM_OF_TAPS = 6,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT     = (2**SIZE) + 8
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         start,
  output logic [NUM_OF_TAPS*TAP_W-1:0] co_buf,
  output logic                         dut_res,
  output logic                         dut_ena,
  input  logic                         dut_found,
  input  logic                         dut_failure,
  output logic                         rd_valid,
  output logic [NUM_OF_TAPS*TAP_W-1:0] rd_data,
  input  logic                         rd_ready,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  tested_cnt,
  output logic [31:0]                  found_cnt,
  output logic [31:0]                  timeout_cnt
);

  localparam int unsigned      CW        = NUM_OF_TAPS * TAP_W;
  localparam int unsigned      M         = SIZE - 1;
  localparam logic [TAP_W-1:0] LAST_TAP1 = TAP_W'(SIZE - NUM_OF_TAPS);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_co_buf;
  logic [31:0]   r_wdog;
  logic [31:0]   r_tested;
  logic [31:0]   r_found;
  logic [31:0]   r_timeout;
  logic          r_done;
  logic          w_start_ok;
  logic          w_push;
  logic          w_pop;
  logic          w_can_push;
  logic          w_timeout_hit;
  logic          w_last;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  // A strictly increasing list is final exactly when its first tap is at its maximum.
  assign w_last     = (r_co_buf[TAP_W-1:0] == LAST_TAP1);
  assign w_pop      = rd_ready && !w_fifo_empty;
  assign w_can_push = !w_fifo_full || w_pop;

  assign co_buf      = r_co_buf;
  assign dut_res     = (r_state == LOAD);
  assign dut_ena     = (r_state == RUN);
  assign busy        = (r_state == LOAD) || (r_state == RUN) ||
                       (r_state == RECORD) || (r_state == ADVANCE);
  assign done        = r_done;
  assign rd_valid    = !w_fifo_empty;
  assign tested_cnt  = r_tested;
  assign found_cnt   = r_found;
  assign timeout_cnt = r_timeout;

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and per-state strobes; found takes priority over failure.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_ok    = 1'b0;
    w_push        = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: w_state_nxt = RUN;
      RUN: begin
        if (dut_found)                     w_state_nxt = RECORD;
        else if (dut_failure)              w_state_nxt = ADVANCE;
        else if (r_wdog == 32'(TIMEOUT-1)) begin
          w_state_nxt   = ADVANCE;
          w_timeout_hit = 1'b1;
        end
      end
      RECORD: begin
        if (w_can_push) begin
          w_push      = 1'b1;
          w_state_nxt = ADVANCE;
        end
      end
      ADVANCE: w_state_nxt = w_last ? DONE : LOAD;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Combination register, watchdog, sticky done flag and saturating statistics.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_co_buf  <= CW'(first_comb(NUM_OF_TAPS));
      r_wdog    <= '0;
      r_tested  <= '0;
      r_found   <= '0;
      r_timeout <= '0;
      r_done    <= 1'b0;
    end else begin
      r_wdog <= (r_state == RUN) ? r_wdog + 32'd1 : '0;
      if (w_start_ok) begin
        r_co_buf  <= CW'(first_comb(NUM_OF_TAPS));
        r_tested  <= '0;
        r_found   <= '0;
        r_timeout <= '0;
        r_done    <= 1'b0;
      end
      if (w_timeout_hit) r_timeout <= sat_inc(r_timeout);
      if (w_push)        r_found   <= sat_inc(r_found);
      if (r_state == ADVANCE) begin
        r_tested <= sat_inc(r_tested);
        if (w_last) r_done   <= 1'b1;
        else        r_co_buf <= CW'(next_comb(COMB_W'(r_co_buf), NUM_OF_TAPS, M));
      end
    end
  end

  nlfsr_result_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (res),
    .i_push  (w_push),
    .i_data  (r_co_buf),
    .i_pop   (w_pop),
    .o_data  (rd_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule

// File: tb/tb_nlfsr_tap_sequencer.sv
// Self-checking bench: behavioural tester models drive two sequencer instances and a
// reference model (sorted subset enumeration plus response log) predicts all outputs.
module tb_nlfsr_tap_sequencer;

  localparam int A_TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Small instance: SIZE=4, K=2, depth 2, short watchdog.
  logic        a_start, a_dut_res, a_dut_ena, a_found, a_fail;
  logic        a_rd_valid, a_rd_ready, a_busy, a_done;
  logic [15:0] a_co_buf, a_rd_data;
  logic [31:0] a_tested, a_found_cnt, a_to_cnt;

  // Large instance: SIZE=11, K=6, default depth and watchdog.
  logic        b_start, b_dut_res, b_dut_ena, b_found, b_fail;
  logic        b_rd_valid, b_rd_ready, b_busy, b_done;
  logic [47:0] b_co_buf, b_rd_data;
  logic [31:0] b_tested, b_found_cnt, b_to_cnt;

  nlfsr_tap_sequencer #(.SIZE(4), .NUM_OF_TAPS(2), .FIFO_DEPTH(2), .TIMEOUT(A_TO)) dut_a (
    .clk(clk), .res(rst_n), .start(a_start), .co_buf(a_co_buf),
    .dut_res(a_dut_res), .dut_ena(a_dut_ena), .dut_found(a_found), .dut_failure(a_fail),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
    .busy(a_busy), .done(a_done), .tested_cnt(a_tested), .found_cnt(a_found_cnt),
    .timeout_cnt(a_to_cnt));

  nlfsr_tap_sequencer #(.SIZE(11), .NUM_OF_TAPS(6)) dut_b (
    .clk(clk), .res(rst_n), .start(b_start), .co_buf(b_co_buf),
    .dut_res(b_dut_res), .dut_ena(b_dut_ena), .dut_found(b_found), .dut_failure(b_fail),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
    .busy(b_busy), .done(b_done), .tested_cnt(b_tested), .found_cnt(b_found_cnt),
    .timeout_cnt(b_to_cnt));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference enumeration: all k-subsets of 1..m, sorted lexicographically, packed tap1 at LSB.
  logic [63:0] combos[$];
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];

  task automatic gen_combos(input int m, input int k);
    logic [63:0] key, cb;
    combos.delete();
    for (int mask = 0; mask < (1 << m); mask++) begin
      if ($countones(mask) == k) begin
        key = '0;
        for (int b = 1; b <= m; b++) if (mask[b-1]) key = (key << 8) | 64'(b);
        combos.push_back(key);
      end
    end
    combos.sort();
    for (int i = 0; i < combos.size(); i++) begin
      key = combos[i];
      cb  = '0;
      for (int t = 0; t < k; t++) cb[t*8 +: 8] = key[(k-1-t)*8 +: 8];
      combos[i] = cb;
    end
  endtask

  // Tester model for instance A. resp: 0 silent, 1 found, 2 failure, 3 both flags.
  int          a_mode, a_fix_lat, pop_pct, a_res_pulses;
  logic [15:0] a_target;
  logic [63:0] a_seen[$];
  int          a_resp_q[$], a_lat_q[$], a_run_q[$];
  logic [63:0] exp_fifo[$];

  initial begin
    int cnt, lat, resp, run;
    bit armed, prev;
    a_found = 0; a_fail = 0; cnt = 0; lat = 0; resp = 0; run = 0; armed = 0; prev = 0;
    forever begin
      @(negedge clk);
      if (a_dut_ena) begin
        run++;
        prev = 1;
      end else if (prev) begin
        a_run_q.push_back(run);
        run = 0;
        prev = 0;
      end
      if (a_dut_res) begin
        a_found = 0; a_fail = 0; cnt = 0; armed = 1; a_res_pulses++;
        case (a_mode)
          0: begin resp = 2; lat = a_fix_lat; end
          1: begin resp = (a_co_buf == a_target) ? 1 : 2; lat = $urandom_range(1, 6); end
          2: begin resp = 0; lat = 0; end
          3: begin resp = 1; lat = $urandom_range(1, 4); end
          default: begin resp = $urandom_range(0, 3); lat = $urandom_range(1, 12); end
        endcase
        a_seen.push_back(64'(a_co_buf));
        a_resp_q.push_back(resp);
        a_lat_q.push_back(lat);
        if (resp == 1 || resp == 3) exp_fifo.push_back(64'(a_co_buf));
      end else if (a_dut_ena && armed) begin
        cnt++;
        if (cnt >= lat && resp != 0) begin
          a_found = (resp == 1 || resp == 3);
          a_fail  = (resp == 2 || resp == 3);
          armed   = 0;
        end
      end
    end
  end

  // Host reader for instance A; each pop is compared with the model's found queue.
  initial begin
    a_rd_ready = 0;
    forever begin
      @(negedge clk);
      a_rd_ready = ($urandom_range(0, 99) < pop_pct);
      if (a_rd_ready && a_rd_valid) begin
        if (exp_fifo.size() == 0) check("pop_unexpected", 64'(a_rd_data), 64'hffff_ffff);
        else                      check("rd_data", 64'(a_rd_data), exp_fifo.pop_front());
      end
    end
  end

  // Tester model for instance B: fails on the first enabled cycle.
  logic [63:0] b_seen[$];
  initial begin
    b_found = 0; b_fail = 0;
    forever begin
      @(negedge clk);
      if (b_dut_res) begin
        b_fail = 0;
        b_seen.push_back(64'(b_co_buf));
      end else if (b_dut_ena) begin
        b_fail = 1;
      end
    end
  end

  task automatic clear_logs_a();
    a_seen.delete(); a_resp_q.delete(); a_lat_q.delete(); a_run_q.delete();
    a_res_pulses = 0;
  endtask

  task automatic start_a();
    @(negedge clk) a_start = 1;
    @(negedge clk) a_start = 0;
  endtask

  task automatic wait_done_a(input int budget);
    int c = 0;
    while (!(a_done && !a_busy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("sweep_done", 64'(a_done), 64'd1);
  endtask

  task automatic check_sweep_a(input string tag);
    int nf = 0, nt = 0;
    check({tag, "_len"}, 64'(a_seen.size()), 64'(exp_a.size()));
    for (int i = 0; i < a_seen.size() && i < exp_a.size(); i++)
      check({tag, "_co_buf"}, a_seen[i], exp_a[i]);
    foreach (a_resp_q[i]) begin
      if (a_resp_q[i] == 1 || a_resp_q[i] == 3) nf++;
      if (a_resp_q[i] == 0) nt++;
    end
    check({tag, "_tested"}, 64'(a_tested), 64'(exp_a.size()));
    check({tag, "_found"}, 64'(a_found_cnt), 64'(nf));
    check({tag, "_timeouts"}, 64'(a_to_cnt), 64'(nt));
    check({tag, "_runs"}, 64'(a_run_q.size()), 64'(a_resp_q.size()));
    for (int i = 0; i < a_run_q.size() && i < a_resp_q.size(); i++)
      check({tag, "_run_len"}, 64'(a_run_q[i]), 64'((a_resp_q[i] == 0) ? A_TO : a_lat_q[i]));
  endtask

  task automatic drain_a();
    int c = 0;
    pop_pct = 100;
    while ((a_rd_valid || exp_fifo.size() != 0) && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("drain_valid", 64'(a_rd_valid), 64'd0);
    check("drain_model", 64'(exp_fifo.size()), 64'd0);
    pop_pct = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n = 0; a_start = 0; b_start = 0; b_rd_ready = 0;
    a_mode = 0; a_fix_lat = 5; a_target = 16'h0301; pop_pct = 0; a_res_pulses = 0;
    gen_combos(3, 2);  exp_a = combos;
    gen_combos(10, 6); exp_b = combos;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_co_buf", 64'(a_co_buf), 64'h0201);
    check("rst_co_buf_b", 64'(b_co_buf), 64'h060504030201);
    check("rst_outs", {58'd0, a_dut_res, a_dut_ena, a_busy, a_done, a_rd_valid, b_busy}, 64'd0);
    check("rst_cnts", 64'(a_tested | a_found_cnt | a_to_cnt), 64'd0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);

    // 1: always failure after 5 cycles
    a_mode = 0; a_fix_lat = 5;
    clear_logs_a(); start_a(); wait_done_a(500);
    check_sweep_a("t1");
    check("t1_busy", 64'(a_busy), 64'd0);
    check("t1_rd_valid", 64'(a_rd_valid), 64'd0);

    // 2: found only for 0x0301
    a_mode = 1;
    clear_logs_a(); start_a(); wait_done_a(500);
    check_sweep_a("t2");
    check("t2_rd_valid", 64'(a_rd_valid), 64'd1);
    check("t2_rd_data", 64'(a_rd_data), 64'h0301);
    drain_a();

    // 3: silent tester, watchdog ends every run
    a_mode = 2;
    clear_logs_a(); start_a(); wait_done_a(500);
    check_sweep_a("t3");
    check("t3_res_pulses", 64'(a_res_pulses), 64'd3);

    // 4: always found, reader stalled until the FIFO backs up
    a_mode = 3; pop_pct = 0;
    clear_logs_a(); start_a();
    c = 0;
    while (a_res_pulses < 3 && c < 200) begin @(negedge clk); c++; end
    repeat (40) @(negedge clk);
    check("t4_stall_busy", 64'(a_busy), 64'd1);
    check("t4_stall_done", 64'(a_done), 64'd0);
    check("t4_stall_ena", 64'(a_dut_ena), 64'd0);
    check("t4_stall_co_buf", 64'(a_co_buf), 64'h0302);
    check("t4_stall_found", 64'(a_found_cnt), 64'd2);
    check("t4_stall_tested", 64'(a_tested), 64'd2);
    pop_pct = 100;
    wait_done_a(200);
    check_sweep_a("t4");
    drain_a();

    // 5: asynchronous reset in the middle of the second run
    a_mode = 0; a_fix_lat = 10;
    clear_logs_a(); start_a();
    c = 0;
    while (a_res_pulses < 2 && c < 200) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    check("t5_pre_ena", 64'(a_dut_ena), 64'd1);
    #2 rst_n = 0;
    #1;
    check("t5_co_buf", 64'(a_co_buf), 64'h0201);
    check("t5_outs", {59'd0, a_dut_res, a_dut_ena, a_busy, a_done, a_rd_valid}, 64'd0);
    check("t5_tested", 64'(a_tested), 64'd0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    exp_fifo.delete();
    a_fix_lat = 5;
    clear_logs_a(); start_a(); wait_done_a(500);
    check_sweep_a("t5");

    // Randomized responses with a randomly stalling reader
    for (int s = 0; s < 4; s++) begin
      a_mode = 4; pop_pct = 50;
      clear_logs_a(); start_a(); wait_done_a(2000);
      check_sweep_a("rnd");
    end
    drain_a();

    // start while busy is ignored
    a_mode = 0; a_fix_lat = 8;
    clear_logs_a(); start_a();
    repeat (4) @(negedge clk);
    start_a();
    wait_done_a(500);
    check_sweep_a("t_busy_start");

    // 6: full-size sweep, tester fails immediately
    @(negedge clk) b_start = 1;
    @(negedge clk) b_start = 0;
    c = 0;
    while (!(b_done && !b_busy) && c < 5000) begin @(negedge clk); c++; end
    check("t6_done", 64'(b_done), 64'd1);
    check("t6_tested", 64'(b_tested), 64'd210);
    check("t6_found", 64'(b_found_cnt | b_to_cnt), 64'd0);
    check("t6_last", 64'(b_co_buf), 64'h0a0908070605);
    check("t6_rd_valid", 64'(b_rd_valid), 64'd0);
    check("t6_len", 64'(b_seen.size()), 64'(exp_b.size()));
    for (int i = 0; i < b_seen.size() && i < exp_b.size(); i++)
      check("t6_co_buf", b_seen[i], exp_b[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
